keypad_scan_debounce: RTL and testbench

- Upstream stage of the stopwatch/calculator top level.
- Drives the row lines of the 4x4 matrix keypad and samples the columns.
- Debounces the press and emits one registered key code with a single-cycle press strobe and a held level.
- Consumers (mode control, operand reader, stopwatch control) act on the strobe, so one physical press produces exactly one event.

---
 rtl/keypad_if.sv | 25 ++
 rtl/keypad_scan_debounce.sv | 167 ++++++++++++++++
 tb/tb_keypad_scan_debounce.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_if.sv
// Keypad matrix and key-event bundle between the scanner and the rest of the top level.
// master = scanner side (drives rows and key events); slave = keypad/consumer side.
interface keypad_if;
   logic [3:0] LINE;
   logic [3:0] COLLUMMN;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_held;

   modport master (
      output LINE,
      output key_code,
      output key_valid,
      output key_held,
      input  COLLUMMN
   );

   modport slave (
      input  LINE,
      input  key_code,
      input  key_valid,
      input  key_held,
      output COLLUMMN
   );
endinterface

// File: rtl/keypad_scan_debounce.sv
// 4x4 keypad row scanner with press/release debouncing.
// Emits one key_valid strobe per accepted press; key_held stays high until the release is debounced.
module keypad_scan_debounce #(
   parameter int SCAN_DIV     = 4,
   parameter int DEBOUNCE_CNT = 8
) (
   input  logic     clk,
   input  logic     rst,
   keypad_if.master kp
);

   localparam logic [1:0] ST_SCAN = 2'd0;
   localparam logic [1:0] ST_DEB  = 2'd1;
   localparam logic [1:0] ST_HELD = 2'd2;

   localparam logic [15:0] SCAN_LAST = 16'(SCAN_DIV - 1);
   localparam logic [15:0] DEB_LAST  = 16'(DEBOUNCE_CNT - 1);

   logic [1:0]  state_q,     state_d;
   logic [1:0]  row_q,       row_d;
   logic [15:0] div_q,       div_d;
   logic [15:0] deb_q,       deb_d;
   logic [3:0]  cand_q,      cand_d;
   logic [3:0]  col_m_q,     col_m_d;
   logic [3:0]  col_s_q,     col_s_d;
   logic [3:0]  key_code_q,  key_code_d;
   logic        key_valid_q, key_valid_d;
   logic        key_held_q,  key_held_d;
   logic [3:0]  line_drv;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   function automatic logic one_low(input logic [3:0] c);
      case (c)
         4'b1110, 4'b1101, 4'b1011, 4'b0111: return 1'b1;
         default:                            return 1'b0;
      endcase
   endfunction

   function automatic logic [1:0] col_index(input logic [3:0] c);
      case (c)
         4'b1101: return 2'd1;
         4'b1011: return 2'd2;
         4'b0111: return 2'd3;
         default: return 2'd0;
      endcase
   endfunction

   // Physical keypad legend: digits, A-D as 10-13, '*' = 14, '#' = 15.
   function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
      case ({r, c})
         4'h0: return 4'd1;   4'h1: return 4'd2;   4'h2: return 4'd3;   4'h3: return 4'd10;
         4'h4: return 4'd4;   4'h5: return 4'd5;   4'h6: return 4'd6;   4'h7: return 4'd11;
         4'h8: return 4'd7;   4'h9: return 4'd8;   4'hA: return 4'd9;   4'hB: return 4'd12;
         4'hC: return 4'd14;  4'hD: return 4'd0;   4'hE: return 4'd15;  default: return 4'd13;
      endcase
   endfunction

   always_comb begin
      state_d     = state_q;
      row_d       = row_q;
      div_d       = div_q;
      deb_d       = deb_q;
      cand_d      = cand_q;
      key_code_d  = key_code_q;
      key_valid_d = 1'b0;
      key_held_d  = key_held_q;
      col_m_d     = kp.COLLUMMN;
      col_s_d     = col_m_q;

      case (state_q)
         ST_SCAN: begin
            if (div_q == SCAN_LAST) begin
               if (one_low(col_s_q)) begin
                  cand_d  = col_s_q;
                  deb_d   = 16'd1;
                  state_d = ST_DEB;
               end else begin
                  // Idle or ghosted multi-key: move on to the next row.
                  row_d = row_q + 2'd1;
                  div_d = 16'd0;
               end
            end else begin
               div_d = sat_inc(div_q);
            end
         end
         ST_DEB: begin
            if (col_s_q == cand_q) begin
               if (deb_q >= DEB_LAST) begin
                  key_code_d  = key_map(row_q, col_index(cand_q));
                  key_valid_d = 1'b1;
                  key_held_d  = 1'b1;
                  state_d     = ST_HELD;
                  deb_d       = 16'd0;
               end else begin
                  deb_d = sat_inc(deb_q);
               end
            end else begin
               state_d = ST_SCAN;
               row_d   = row_q + 2'd1;
               div_d   = 16'd0;
               deb_d   = 16'd0;
            end
         end
         ST_HELD: begin
            // Only an unbroken run of all-high samples counts as a release.
            if (col_s_q == 4'hF) begin
               if (deb_q >= DEB_LAST) begin
                  key_held_d = 1'b0;
                  state_d    = ST_SCAN;
                  row_d      = 2'd0;
                  div_d      = 16'd0;
                  deb_d      = 16'd0;
               end else begin
                  deb_d = sat_inc(deb_q);
               end
            end else begin
               deb_d = 16'd0;
            end
         end
         default: begin
            state_d = ST_SCAN;
            row_d   = 2'd0;
            div_d   = 16'd0;
            deb_d   = 16'd0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_SCAN;
         row_q       <= 2'd0;
         div_q       <= 16'd0;
         deb_q       <= 16'd0;
         cand_q      <= 4'hF;
         col_m_q     <= 4'hF;
         col_s_q     <= 4'hF;
         key_code_q  <= 4'd0;
         key_valid_q <= 1'b0;
         key_held_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         row_q       <= row_d;
         div_q       <= div_d;
         deb_q       <= deb_d;
         cand_q      <= cand_d;
         col_m_q     <= col_m_d;
         col_s_q     <= col_s_d;
         key_code_q  <= key_code_d;
         key_valid_q <= key_valid_d;
         key_held_q  <= key_held_d;
      end
   end

   for (genvar gi = 0; gi < 4; gi++) begin : g_line
      assign line_drv[gi] = (row_q != 2'(gi));
   end

   assign kp.LINE      = line_drv;
   assign kp.key_code  = key_code_q;
   assign kp.key_valid = key_valid_q;
   assign kp.key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Directed bench for keypad_scan_debounce: a keypad matrix model drives the columns,
// expected key codes go into a scoreboard queue that a separate monitor drains on each strobe.
module tb_keypad_scan_debounce;

   typedef struct {
      string name;
      int    act;
      int    exp;
   } chk_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   keypad_if kp ();

   keypad_scan_debounce #(
      .SCAN_DIV     (4),
      .DEBOUNCE_CNT (8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .kp  (kp)
   );

   logic [3:0] press_mask [4];
   logic       bounce_open;
   logic [3:0] low_cols;

   // Matrix model: a pressed key pulls its column low only while its row is driven.
   always_comb begin
      low_cols = 4'h0;
      for (int r = 0; r < 4; r++)
         if (kp.LINE[r] == 1'b0) low_cols = low_cols | press_mask[r];
      kp.COLLUMMN = bounce_open ? 4'hF : ~low_cols;
   end

   int   n_cmp = 0;
   int   n_bad = 0;
   chk_t chk_q [$];
   int   exp_q [$];

   // Monitor: the only process that counts comparisons.
   initial begin
      chk_t c;
      int   e;
      logic prev_valid;
      logic prev_held;
      prev_valid = 1'b0;
      prev_held  = 1'b0;
      forever begin
         @(negedge clk);
         while (chk_q.size() > 0) begin
            c = chk_q.pop_front();
            n_cmp++;
            if (c.act != c.exp) begin
               n_bad++;
               $display("FAIL %s: actual=%0d required=%0d", c.name, c.act, c.exp);
            end
         end
         if (kp.key_valid === 1'b1) begin
            n_cmp++;
            if (prev_valid === 1'b1 || prev_held === 1'b1) begin
               n_bad++;
               $display("FAIL strobe_invariant: prev_valid=%0b prev_held=%0b required 0/0",
                        prev_valid, prev_held);
            end
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_bad++;
               $display("FAIL unexpected_strobe: actual code=%0d required no strobe", kp.key_code);
            end else begin
               e = exp_q.pop_front();
               if (int'(kp.key_code) != e) begin
                  n_bad++;
                  $display("FAIL strobe_code: actual=%0d required=%0d", kp.key_code, e);
               end else begin
                  $display("strobe key_code=%0d at %0t", kp.key_code, $time);
               end
            end
         end
         prev_valid = kp.key_valid;
         prev_held  = kp.key_held;
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      chk_q.push_back('{name, act, exp});
   endtask

   task automatic wait_held(input logic lvl, input int bound, input string name);
      int n;
      n = 0;
      while (kp.key_held !== lvl && n < bound) begin
         @(negedge clk);
         n++;
      end
      chk(name, (kp.key_held === lvl) ? 1 : 0, 1);
   endtask

   // Leaves the caller at the first negedge after the row pointer returns to row 0.
   task automatic sync_row0(input string name);
      int         n;
      int         found;
      logic [3:0] prev;
      n     = 0;
      found = 0;
      prev  = kp.LINE;
      while (found == 0 && n < 40) begin
         @(negedge clk);
         n++;
         if (prev != 4'b1110 && kp.LINE == 4'b1110) found = 1;
         prev = kp.LINE;
      end
      chk(name, found, 1);
   endtask

   initial begin
      int seq [4];
      seq[0] = 14; seq[1] = 13; seq[2] = 11; seq[3] = 7;
      bounce_open = 1'b0;
      for (int r = 0; r < 4; r++) press_mask[r] = 4'h0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_line", kp.LINE, 14);
      chk("reset_code", kp.key_code, 0);
      chk("reset_valid", kp.key_valid, 0);
      chk("reset_held", kp.key_held, 0);
      rst = 1'b0;
      @(negedge clk);

      // Key '5', held long, then clean release.
      exp_q.push_back(5);
      press_mask[1] = 4'b0010;
      wait_held(1'b1, 100, "t1_accept");
      chk("t1_code", kp.key_code, 5);
      chk("t1_line", kp.LINE, 13);
      for (int i = 0; i < 4; i++) begin
         repeat (40) @(negedge clk);
         chk("t1_frozen_line", kp.LINE, 13);
         chk("t1_frozen_held", kp.key_held, 1);
      end
      press_mask[1] = 4'h0;
      repeat (9) @(negedge clk);
      chk("t1_held_before_release", kp.key_held, 1);
      @(negedge clk);
      chk("t1_released", kp.key_held, 0);
      chk("t1_line_row0", kp.LINE, 14);
      chk("t1_code_kept", kp.key_code, 5);

      // Key 'D' with contact bounce every 3 cycles.
      press_mask[3] = 4'b1000;
      for (int i = 0; i < 10; i++) begin
         bounce_open = (i % 2 == 0);
         repeat (3) @(negedge clk);
      end
      chk("t2_no_held_in_bounce", kp.key_held, 0);
      exp_q.push_back(13);
      bounce_open = 1'b0;
      wait_held(1'b1, 100, "t2_accept");
      chk("t2_code", kp.key_code, 13);
      press_mask[3] = 4'h0;
      wait_held(1'b0, 40, "t2_release");

      // Key 'A' with release bounce: 5 high, 2 low, then high.
      exp_q.push_back(10);
      press_mask[0] = 4'b1000;
      wait_held(1'b1, 100, "t3_accept");
      chk("t3_code", kp.key_code, 10);
      repeat (10) @(negedge clk);
      press_mask[0] = 4'h0;
      repeat (5) @(negedge clk);
      press_mask[0] = 4'b1000;
      repeat (2) @(negedge clk);
      press_mask[0] = 4'h0;
      chk("t3_held_mid_bounce", kp.key_held, 1);
      repeat (9) @(negedge clk);
      chk("t3_held_before_release", kp.key_held, 1);
      @(negedge clk);
      chk("t3_released", kp.key_held, 0);

      // Ghosting on row 0: scanning must continue with a 16-cycle period.
      press_mask[0] = 4'b0011;
      sync_row0("t4_sync");
      for (int k = 1; k <= 8; k++) begin
         repeat (4) @(negedge clk);
         chk("t4_line_cycle", kp.LINE, seq[k % 4]);
      end
      chk("t4_no_held", kp.key_held, 0);
      press_mask[0] = 4'h0;

      // Reset after 4 matching samples of '7'.
      sync_row0("t5_sync");
      repeat (8) @(negedge clk);
      press_mask[2] = 4'b0001;
      repeat (7) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("t5_rst_line", kp.LINE, 14);
      chk("t5_rst_held", kp.key_held, 0);
      chk("t5_rst_code", kp.key_code, 0);
      chk("t5_rst_valid", kp.key_valid, 0);
      exp_q.push_back(7);
      wait_held(1'b1, 100, "t5_accept");
      chk("t5_code", kp.key_code, 7);
      press_mask[2] = 4'h0;
      wait_held(1'b0, 40, "t5_release");

      // 5-cycle glitch on row 2: debounce aborts and scanning resumes at row 3.
      sync_row0("t6_sync");
      repeat (8) @(negedge clk);
      press_mask[2] = 4'b0001;
      repeat (5) @(negedge clk);
      press_mask[2] = 4'h0;
      @(negedge clk);
      chk("t6_frozen_row2", kp.LINE, 11);
      repeat (2) @(negedge clk);
      chk("t6_resume_row3", kp.LINE, 7);
      chk("t6_no_held", kp.key_held, 0);

      repeat (5) @(negedge clk);
      chk("scoreboard_empty", exp_q.size(), 0);
      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
